// File: rtl/regfile_sb.sv
// regfile_sb: N-read/1-write register file with hardwired x0, write bypass, pending-write scoreboard and sequenced clear
module regfile_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int BYPASS        = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we3,
    input  logic [ADDRESS_WIDTH-1:0]           ad3,
    input  logic [DATA_WIDTH-1:0]              wd3,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  ra,
    output logic [NUM_READ*DATA_WIDTH-1:0]     rd,
    output logic [NUM_READ-1:0]                rd_pend,
    input  logic                               iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]           iss_ad,
    output logic                               iss_ready,
    input  logic                               clr_req,
    output logic                               clr_busy,
    output logic                               clr_done
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                   r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_cnt;
    logic                     r_done;
    logic [DATA_WIDTH-1:0]    r_rf [DEPTH];
    logic [DEPTH-1:0]         r_pend;
    logic                     w_last, w_wr, w_iss;
    assign clr_busy  = r_state == CLEAR;
    assign iss_ready = !clr_busy;
    assign clr_done  = r_done;
    assign w_last    = clr_busy && r_cnt == '1;
    assign w_wr      = we3 && ad3 != '0 && !clr_busy;
    assign w_iss     = iss_valid && iss_ad != '0 && !clr_busy;
    // clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    // enter CLEAR on request from IDLE, leave after the all-ones entry is zeroed
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && clr_req) w_state_nxt = CLEAR;
        else if (w_last)                w_state_nxt = IDLE;
    end
    // sweep counter restarts at 1 whenever not mid-sweep; done pulses after the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= ADDRESS_WIDTH'(1);
            r_done <= 1'b0;
        end else begin
            r_cnt  <= clr_busy && !w_last ? r_cnt + 1'b1 : ADDRESS_WIDTH'(1);
            r_done <= w_last;
        end
    end
    // storage: sweep zeroing takes priority, otherwise accepted writes land
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
        end else if (clr_busy) begin
            r_rf[r_cnt] <= '0;
        end else if (w_wr) begin
            r_rf[ad3] <= wd3;
        end
    end
    // scoreboard: a write retires a producer, a same-cycle issue re-arms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (clr_busy) begin
            r_pend[r_cnt] <= 1'b0;
        end else begin
            if (w_wr)  r_pend[ad3]    <= 1'b0;
            if (w_iss) r_pend[iss_ad] <= 1'b1;
        end
    end
    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_ra;
        logic                     w_byp;
        assign w_ra                         = ra[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_byp                        = BYPASS != 0 && w_wr && ad3 == w_ra;
        assign rd[g*DATA_WIDTH +: DATA_WIDTH] = w_ra == '0 ? '0 : w_byp ? wd3 : r_rf[w_ra];
        assign rd_pend[g]                   = r_pend[w_ra] && !w_byp;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized scoreboard bench comparing bypass and non-bypass register files to a reference model
module tb_regfile_sb;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;
    typedef struct {
        logic [NR*DW-1:0] rd, rd_nb;
        logic [NR-1:0]    pend, pend_nb;
        logic             busy, ready, done;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n, we3, iss_valid, clr_req;
    logic [AW-1:0] ad3, iss_ad;
    logic [DW-1:0] wd3;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd_b, rd_n;
    logic [NR-1:0] pend_b, pend_n;
    logic ready_b, busy_b, done_b, ready_n, busy_n, done_n;
    exp_t q[$];
    int total = 0;
    int passed = 0;
    logic [DW-1:0] m_rf [32];
    logic [31:0] m_pend;
    logic m_busy, m_done;
    int m_pos;
    always #5 clk = ~clk;
    regfile_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we3(we3), .ad3(ad3), .wd3(wd3), .ra(ra), .rd(rd_b), .rd_pend(pend_b),
        .iss_valid(iss_valid), .iss_ad(iss_ad), .iss_ready(ready_b), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));
    regfile_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we3(we3), .ad3(ad3), .wd3(wd3), .ra(ra), .rd(rd_n), .rd_pend(pend_n),
        .iss_valid(iss_valid), .iss_ad(iss_ad), .iss_ready(ready_n), .clr_req(clr_req), .clr_busy(busy_n), .clr_done(done_n));
    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pend = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_pos = 1;
    endtask
    function automatic exp_t expect_now();
        exp_t e;
        logic wa, hit;
        logic [AW-1:0] a;
        wa = we3 && ad3 != 0 && !m_busy;
        for (int i = 0; i < NR; i++) begin
            a = ra[i*AW +: AW];
            hit = wa && ad3 == a;
            e.rd[i*DW +: DW]    = a == 0 ? '0 : hit ? wd3 : m_rf[a];
            e.rd_nb[i*DW +: DW] = a == 0 ? '0 : m_rf[a];
            e.pend[i]    = m_pend[a] && !hit;
            e.pend_nb[i] = m_pend[a];
        end
        e.busy  = m_busy;
        e.ready = !m_busy;
        e.done  = m_done;
        return e;
    endfunction
    task automatic m_edge();
        logic nd;
        nd = 1'b0;
        if (m_busy) begin
            m_rf[m_pos] = '0;
            m_pend[m_pos] = 1'b0;
            if (m_pos == 31) begin
                m_busy = 1'b0;
                nd = 1'b1;
            end else m_pos++;
        end else begin
            if (we3 && ad3 != 0) begin
                m_rf[ad3] = wd3;
                m_pend[ad3] = 1'b0;
            end
            if (iss_valid && iss_ad != 0) m_pend[iss_ad] = 1'b1;
            if (clr_req) begin
                m_busy = 1'b1;
                m_pos = 1;
            end
        end
        m_done = nd;
    endtask
    task automatic step(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic iv, input logic [AW-1:0] ia, input logic cr, input logic rn);
        we3 = w; ad3 = a; wd3 = d; ra = {r2, r1, r0};
        iss_valid = iv; iss_ad = ia; clr_req = cr; rst_n = rn;
        if (!rn) m_reset();
        q.push_back(expect_now());
        @(posedge clk);
        if (rn) m_edge();
        #1;
    endtask
    function automatic logic [AW-1:0] rnd_a();
        return $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
    endfunction
    task automatic chk(input string n, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        else passed++;
    endtask
    // monitor: pop the expected response for this cycle and compare away from the clock edge
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("rd_bypass", rd_b, e.rd);
            chk("rd_nobypass", rd_n, e.rd_nb);
            chk("pend_bypass", {93'b0, pend_b}, {93'b0, e.pend});
            chk("pend_nobypass", {93'b0, pend_n}, {93'b0, e.pend_nb});
            chk("ctrl_bypass", {93'b0, busy_b, ready_b, done_b}, {93'b0, e.busy, e.ready, e.done});
            chk("ctrl_nobypass", {93'b0, busy_n, ready_n, done_n}, {93'b0, e.busy, e.ready, e.done});
        end
    end
    task automatic fill();
        for (int i = 1; i < 32; i++) step(1, AW'(i), DW'(i), AW'(i), 0, 0, 0, 0, 0, 1);
    endtask
    initial begin
        rst_n = 0; we3 = 0; ad3 = 0; wd3 = 0; ra = 0; iss_valid = 0; iss_ad = 0; clr_req = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 5, 9, 31, 0, 0, 0, 0);
        step(0, 0, 0, 5, 9, 31, 0, 0, 0, 1);
        step(1, 5, 32'hDEADBEEF, 1, 2, 3, 0, 0, 0, 1);
        step(1, 0, 32'h1234, 5, 0, 5, 0, 0, 0, 1);
        step(0, 0, 0, 5, 0, 0, 0, 0, 0, 1);
        step(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0, 0, 1);
        step(0, 0, 0, 7, 0, 0, 1, 9, 0, 1);
        step(0, 0, 0, 9, 9, 0, 0, 0, 0, 1);
        step(1, 9, 32'h99, 9, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 9, 0, 0, 0, 0, 0, 1);
        step(1, 9, 32'h98, 9, 0, 0, 1, 9, 0, 1);
        step(0, 0, 0, 9, 9, 9, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 3, 3, 0, 0, 0, 0, 1);
        fill();
        step(0, 0, 0, 1, 2, 31, 1, 4, 1, 1);
        for (int i = 0; i < 33; i++) step(1, rnd_a(), $urandom, rnd_a(), rnd_a(), 31, 1, rnd_a(), 1'($urandom_range(0, 1)), 1);
        for (int i = 0; i < 32; i += 3) step(0, 0, 0, AW'(i), AW'(i + 1), AW'(i + 2), 0, 0, 0, 1);
        fill();
        step(0, 0, 0, 20, 25, 31, 1, 20, 1, 1);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 20, 25, 31, 0, 0, 0, 1);
        step(0, 0, 0, 20, 25, 31, 0, 0, 0, 0);
        step(0, 0, 0, 20, 25, 31, 0, 0, 0, 1);
        for (int n = 0; n < 1500; n++)
            step(1'($urandom_range(0, 1)), rnd_a(), $urandom, rnd_a(), rnd_a(), rnd_a(),
                 $urandom_range(0, 2) == 0, rnd_a(), $urandom_range(0, 59) == 0, $urandom_range(0, 299) != 0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
